// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and default widths for the fifo write arbiter
package fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates among all requesters, OWN serves one owner's burst.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Defaults shared with the fifo this arbiter feeds.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N_REQ      = 4;
    localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority search: first set req bit at or above ptr, wrapping
//
// Ports:
//   req_i     N_REQ      request vector
//   ptr_i     PTR_WIDTH  highest-priority index
//   found_o   1          at least one request set
//   winner_o  PTR_WIDTH  index of the winning request (0 when none)
module rr_pick #(
    parameter int N_REQ     = 4,
    parameter int PTR_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]     req_i,
    input  logic [PTR_WIDTH-1:0] ptr_i,
    output logic                 found_o,
    output logic [PTR_WIDTH-1:0] winner_o
);

    int idx;

    // Scan from the farthest offset down so the closest hit to ptr is written last.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (req_i[idx[PTR_WIDTH-1:0]]) begin
                found_o  = 1'b1;
                winner_o = idx[PTR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one fifo write port
//
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   req           per-requester level request, held until ack
//   req_data      flat data bus, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack           one-cycle pulse when a requester's word is captured
//   grant         one-hot current burst owner, zero when idle
//   fifo_full     fifo full flag
//   fifo_wr       fifo write strobe
//   fifo_w_data   fifo write data (holding register)
//   busy          holding register valid or a burst is in progress
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_REQ      = DEF_N_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            grant,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_WIDTH-1:0]       fifo_w_data,
    output logic                        busy
);

    localparam int PTR_WIDTH = $clog2(N_REQ);
    localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

    state_t                  state_q, state_d;
    logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
    logic [PTR_WIDTH-1:0]    owner_q, owner_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;

    logic                    load;
    logic                    found;
    logic [PTR_WIDTH-1:0]    winner;
    logic                    capture;
    logic [PTR_WIDTH-1:0]    cap_idx;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic [N_REQ-1:0]        ack_raw;

    function automatic logic [PTR_WIDTH-1:0] next_idx(input logic [PTR_WIDTH-1:0] i);
        return (i == PTR_WIDTH'(N_REQ - 1)) ? '0 : i + PTR_WIDTH'(1);
    endfunction

    rr_pick #(
        .N_REQ     (N_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    assign fifo_wr     = hold_valid_q & ~fifo_full;
    assign fifo_w_data = hold_data_q;
    // The holding register can take a word when empty or when it drains this cycle.
    assign load        = ~hold_valid_q | fifo_wr;
    assign busy        = hold_valid_q | (state_q == ST_OWN);
    assign cnt_inc     = cnt_q + CNT_WIDTH'(1);
    // ack is combinational on req; mask it so no pulse escapes while reset is held.
    assign ack         = ack_raw & {N_REQ{~reset}};

    always_comb begin
        grant = '0;
        if (state_q == ST_OWN) begin
            grant[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        capture      = 1'b0;
        cap_idx      = owner_q;
        ack_raw      = '0;

        if (fifo_wr) begin
            hold_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (load && found) begin
                    capture = 1'b1;
                    cap_idx = winner;
                    cnt_d   = CNT_WIDTH'(1);
                    if (BURST_LEN > 1) begin
                        state_d = ST_OWN;
                        owner_d = winner;
                    end else begin
                        ptr_d = next_idx(winner);
                    end
                end
            end
            ST_OWN: begin
                if (!req[owner_q]) begin
                    // Owner released early: give up the port, no word this cycle.
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(owner_q);
                end else if (load) begin
                    capture = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_WIDTH'(BURST_LEN)) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_idx(owner_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            hold_valid_d     = 1'b1;
            hold_data_d      = req_data[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH];
            ack_raw[cap_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule
